pixel_buf_arbiter: RTL

PIXEL_BUF_ARBITER -- requirements
Module: pixel_buf_arbiter

---
 rtl/pixel_buf_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pixel_buf_arbiter.sv
// pixel_buf_arbiter: buffers camera pixels through a small skid FIFO into a
// single-port frame memory, and shares that port with processor reads.
// Ports:
//   clk, reset (async, active-low)
//   vsync, pixelValid, pixelIn              camera side
//   rdReq, rdAddr, rdReady, rdValid, rdData processor read side
//   memBusy, memEn, memWe, memAddr, memDin, memDout   memory port
//   frameDone (pulse), overflow (sticky)    status
module pixel_buf_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240,
    parameter int unsigned FIFO_D    = 4,
    parameter int unsigned WR_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              pixelValid,
    input  logic [DATA_W-1:0] pixelIn,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdReady,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    input  logic              memBusy,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDin,
    input  logic [DATA_W-1:0] memDout,
    output logic              frameDone,
    output logic              overflow
);

    localparam int unsigned PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {WAIT, ACTIVE, DROP} state_t;

    state_t            state_q, state_d;
    logic              vsync_q;
    logic              vsync_rise;
    logic [DATA_W-1:0] fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  occ;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_pend;
    logic              do_wr, do_rd, last_wr, push, push_ok, flush, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign vsync_rise = vsync & ~vsync_q;
    assign full       = (occ == CNT_W'(FIFO_D));
    // A full FIFO still accepts a pixel when the head is popped in the same cycle.
    assign push_ok    = push & (~full | do_wr);

    // Arbitration, frame control and next-state logic.
    always_comb begin
        state_d = state_q;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        if (reset) begin
            // Writes are held off in the vsync cycle because the FIFO is being flushed.
            do_wr = ~memBusy & ~vsync_rise & (occ != '0) &
                    ((occ >= CNT_W'(WR_THRESH)) | ~rdReq);
            do_rd = ~memBusy & rdReq & ~do_wr;
        end
        last_wr = do_wr & (wr_addr == LAST_ADDR);
        push    = pixelValid & (state_q == ACTIVE) & ~vsync_rise & ~last_wr;
        flush   = vsync_rise | last_wr;
        case (state_q)
            WAIT:    if (vsync_rise) state_d = ACTIVE;
            ACTIVE:  if (vsync_rise) state_d = ACTIVE;
                     else if (last_wr) state_d = DROP;
            DROP:    if (vsync_rise) state_d = ACTIVE;
            default: state_d = WAIT;
        endcase
    end

    // Memory port is driven in the grant cycle; idle fields are forced to zero.
    always_comb begin
        memEn   = do_wr | do_rd;
        memWe   = do_wr;
        rdReady = do_rd;
        memAddr = '0;
        memDin  = '0;
        if (do_wr) begin
            memAddr = wr_addr;
            memDin  = fifo_mem[rd_ptr];
        end else if (do_rd) begin
            memAddr = rdAddr;
        end
    end

    // State, FIFO control, write counter and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT;
            vsync_q   <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            wr_addr   <= '0;
            overflow  <= 1'b0;
            frameDone <= 1'b0;
            rd_pend   <= 1'b0;
            rdValid   <= 1'b0;
            rdData    <= '0;
        end else begin
            state_q   <= state_d;
            vsync_q   <= vsync;
            frameDone <= last_wr;
            rd_pend   <= do_rd;
            rdValid   <= rd_pend;
            if (rd_pend) rdData <= memDout;
            if (push & full & ~do_wr) overflow <= 1'b1;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
                if (do_wr)   rd_ptr <= ptr_inc(rd_ptr);
                case ({push_ok, do_wr})
                    2'b10:   occ <= occ + CNT_W'(1);
                    2'b01:   occ <= occ - CNT_W'(1);
                    default: occ <= occ;
                endcase
            end

            if (vsync_rise)   wr_addr <= '0;
            else if (last_wr) wr_addr <= '0;
            else if (do_wr)   wr_addr <= wr_addr + ADDR_W'(1);
        end
    end

    // FIFO storage; contents are only read when occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) fifo_mem[wr_ptr] <= pixelIn;
    end

endmodule
